// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 receive path.
package rs232_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

endpackage : rs232_pkg

// File: rtl/rs232_rx_sync.sv
// Metastability synchronizer for the asynchronous serial line; resets to idle level.
module rs232_rx_sync
   import rs232_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw line through the flop chain; reset to idle so no false start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{LINE_IDLE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

endmodule : rs232_rx_sync

// File: rtl/rs232_receiver.sv
// 8N1 serial receiver: start-bit qualification at mid-bit, LSB-first data,
// stop-bit check with one-shot framing error and break hold-off.
module rs232_receiver
   import rs232_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned HALF  = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 cnt_last;

   rs232_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rx),
      .rx_s (rx_s)
   );

   // Start state waits half a bit to land on mid-bit; all later states wait a full bit.
   assign cnt_last = (state_q == START) ? (cnt_q == CNT_W'(HALF - 1))
                                        : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // Next-state, counter, shift register and output pulse logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (rx_s != LINE_IDLE) begin
               state_d = START;
            end
         end

         START: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (rx_s != LINE_IDLE) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt_last) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (rx_s == LINE_IDLE) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         BREAK: begin
            cnt_d = '0;
            if (rx_s == LINE_IDLE) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);

endmodule : rs232_receiver
